// File: rtl/soc_noc_credit_tx_if.sv
// Bundle of per-VC upstream flits, the credited link output and credit returns for soc_noc_credit_tx.
// Handshake: an upstream flit on VC i moves when in_valid[i] & in_ready[i] are both high at a rising clk; the link has no back-pressure, link_valid is a one-cycle strobe.
interface soc_noc_credit_tx_if #(
    parameter int FLIT_WIDTH = 32,
    parameter int CHANNELS   = 2,
    parameter int CREDITS    = 4
);
    localparam int CW = $clog2(CREDITS + 1);

    logic [CHANNELS*FLIT_WIDTH-1:0] in_flit;
    logic [CHANNELS-1:0]            in_last;
    logic [CHANNELS-1:0]            in_valid;
    logic [CHANNELS-1:0]            in_ready;
    logic [FLIT_WIDTH-1:0]          link_flit;
    logic                           link_last;
    logic                           link_valid;
    logic [CHANNELS-1:0]            link_vc;
    logic [CHANNELS-1:0]            credit_return;
    // Observation taps: FSM state (0 idle, 1 locked) and packed per-VC credit counters
    logic                           dbg_state;
    logic [CHANNELS*CW-1:0]         dbg_credit;

    modport master (
        output in_flit, in_last, in_valid, credit_return,
        input  in_ready, link_flit, link_last, link_valid, link_vc, dbg_state, dbg_credit
    );

    modport slave (
        input  in_flit, in_last, in_valid, credit_return,
        output in_ready, link_flit, link_last, link_valid, link_vc, dbg_state, dbg_credit
    );
endinterface

// File: rtl/soc_noc_credit_tx.sv
// Credit-based NoC link transmitter: round-robin VC arbitration with per-packet lock and per-VC credits.
// Optional sticky overflow flag 'err' is built when SOC_NOC_CREDIT_TX_ERR_EN is defined.
module soc_noc_credit_tx #(
    parameter int FLIT_WIDTH = 32,
    parameter int CHANNELS   = 2,
    parameter int CREDITS    = 4
) (
    input logic                clk,
    input logic                rst,
    soc_noc_credit_tx_if.slave bus
`ifdef SOC_NOC_CREDIT_TX_ERR_EN
    ,
    output logic               err
`endif
);
    localparam int CW  = $clog2(CREDITS + 1);
    localparam int IW  = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
    localparam int IW1 = IW + 1;

    localparam logic [0:0]     ST_IDLE   = 1'b0;
    localparam logic [0:0]     ST_LOCKED = 1'b1;
    localparam logic [CW-1:0]  CRED_MAX  = CW'(CREDITS);
    localparam logic [CW-1:0]  CRED_ONE  = CW'(1);
    localparam logic [IW1-1:0] CH_N      = IW1'(CHANNELS);

    logic [0:0]          state;
    logic [IW-1:0]       rr;
    logic [IW-1:0]       sel;
    logic [CW-1:0]       credit [CHANNELS];
    logic [CHANNELS-1:0] has_credit;
    logic [CHANNELS-1:0] full;
    logic                found;
    logic [IW-1:0]       grant;
    logic [IW1-1:0]      idx_w;
    logic [IW-1:0]       cur;
    logic [CHANNELS-1:0] ready_vec;
    logic [CHANNELS-1:0] xfer_vec;
    logic                xfer;
    logic                xfer_last;
    logic [FLIT_WIDTH-1:0] xfer_flit;
    logic [CHANNELS-1:0] xfer_vc;

    function automatic logic [IW-1:0] wrap_inc(input logic [IW-1:0] v);
        logic [IW1-1:0] t;
        t = {1'b0, v} + IW1'(1);
        if (t >= CH_N) t = '0;
        return t[IW-1:0];
    endfunction

    always_comb begin
        has_credit = '0;
        full       = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            has_credit[i] = (credit[i] != '0);
            full[i]       = (credit[i] == CRED_MAX);
        end
    end

    // First eligible VC at or above rr, wrapping around
    always_comb begin
        found = 1'b0;
        grant = '0;
        idx_w = '0;
        for (int k = 0; k < CHANNELS; k++) begin
            idx_w = {1'b0, rr} + IW1'(k);
            if (idx_w >= CH_N) idx_w = idx_w - CH_N;
            if (!found && bus.in_valid[idx_w[IW-1:0]] && has_credit[idx_w[IW-1:0]]) begin
                found = 1'b1;
                grant = idx_w[IW-1:0];
            end
        end
    end

    always_comb begin
        ready_vec = '0;
        if (state == ST_IDLE) begin
            if (found) ready_vec[grant] = 1'b1;
        end else begin
            ready_vec[sel] = has_credit[sel];
        end
    end

    assign cur          = (state == ST_IDLE) ? grant : sel;
    assign bus.in_ready = rst ? ready_vec : '0;
    assign xfer_vec     = bus.in_valid & bus.in_ready;
    assign xfer         = |xfer_vec;
    assign xfer_last    = bus.in_last[cur];

    always_comb begin
        xfer_flit = '0;
        xfer_vc   = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            if (cur == IW'(i)) begin
                xfer_flit  = bus.in_flit[i*FLIT_WIDTH +: FLIT_WIDTH];
                xfer_vc[i] = 1'b1;
            end
        end
    end

    // A lock is held across credit starvation so packets never interleave
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= ST_IDLE;
            rr    <= '0;
            sel   <= '0;
        end else if (xfer) begin
            if (state == ST_IDLE) begin
                if (xfer_last) begin
                    rr <= wrap_inc(grant);
                end else begin
                    state <= ST_LOCKED;
                    sel   <= grant;
                end
            end else if (xfer_last) begin
                state <= ST_IDLE;
                rr    <= wrap_inc(sel);
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            bus.link_valid <= 1'b0;
            bus.link_last  <= 1'b0;
            bus.link_flit  <= '0;
            bus.link_vc    <= '0;
        end else begin
            bus.link_valid <= xfer;
            if (xfer) begin
                bus.link_last <= xfer_last;
                bus.link_flit <= xfer_flit;
                bus.link_vc   <= xfer_vc;
            end
        end
    end

    // Simultaneous spend and return cancel; returns into a full counter saturate
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < CHANNELS; i++) credit[i] <= CRED_MAX;
        end else begin
            for (int i = 0; i < CHANNELS; i++) begin
                if (bus.credit_return[i] && !xfer_vec[i]) begin
                    if (!full[i]) credit[i] <= credit[i] + CRED_ONE;
                end else if (!bus.credit_return[i] && xfer_vec[i]) begin
                    credit[i] <= credit[i] - CRED_ONE;
                end
            end
        end
    end

`ifdef SOC_NOC_CREDIT_TX_ERR_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) err <= 1'b0;
        else if (|(bus.credit_return & full)) err <= 1'b1;
    end
`endif

    always_comb begin
        bus.dbg_state  = state[0];
        bus.dbg_credit = '0;
        for (int i = 0; i < CHANNELS; i++) bus.dbg_credit[i*CW +: CW] = credit[i];
    end
endmodule

// File: tb/tb_soc_noc_credit_tx.sv
// Directed bench for soc_noc_credit_tx: scoreboard queue of expected link flits plus point checks.
module tb_soc_noc_credit_tx;
    localparam int FW = 32;
    localparam int CH = 2;
    localparam int CR = 4;
    localparam int CW = 3;
    localparam int W  = CH + 1 + FW;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    soc_noc_credit_tx_if #(.FLIT_WIDTH(FW), .CHANNELS(CH), .CREDITS(CR)) bus ();

`ifdef SOC_NOC_CREDIT_TX_ERR_EN
    logic err;
    soc_noc_credit_tx #(.FLIT_WIDTH(FW), .CHANNELS(CH), .CREDITS(CR)) dut (
        .clk(clk), .rst(rst), .bus(bus), .err(err));
`else
    soc_noc_credit_tx #(.FLIT_WIDTH(FW), .CHANNELS(CH), .CREDITS(CR)) dut (
        .clk(clk), .rst(rst), .bus(bus));
`endif

    logic [W-1:0] exp_q[$];
    logic [W-1:0] mon_e;
    int total = 0;
    int bad   = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [CW-1:0] cred(input int i);
        return bus.dbg_credit[i*CW +: CW];
    endfunction

    task automatic expect_flit(input logic [CH-1:0] vc, input logic last, input logic [FW-1:0] f);
        exp_q.push_back({vc, last, f});
    endtask

    // Drive one cycle of inputs just after the falling edge
    task automatic put(input logic [CH-1:0] v, input logic [CH-1:0] last,
                       input logic [FW-1:0] f0, input logic [FW-1:0] f1, input logic [CH-1:0] cr);
        @(negedge clk);
        bus.in_valid      = v;
        bus.in_last       = last;
        bus.in_flit       = {f1, f0};
        bus.credit_return = cr;
        #1;
    endtask

    task automatic idle();
        put(2'b00, 2'b00, '0, '0, 2'b00);
    endtask

    always @(posedge clk) begin
        #1;
        if (rst && bus.link_valid) begin
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL link_unexpected: got %0h expected none", {bus.link_vc, bus.link_last, bus.link_flit});
            end else begin
                mon_e = exp_q.pop_front();
                chk("link_flit", {bus.link_vc, bus.link_last, bus.link_flit}, mon_e);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        bad++;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        bus.in_valid = '0; bus.in_last = '0; bus.in_flit = '0; bus.credit_return = '0;
        repeat (2) @(negedge clk);
        #1;
        chk("rst_link_valid", bus.link_valid, 0);
        chk("rst_link_vc", bus.link_vc, 0);
        chk("rst_in_ready", bus.in_ready, 0);
        chk("rst_credit0", cred(0), 4);
        chk("rst_credit1", cred(1), 4);
        chk("rst_state", bus.dbg_state, 0);
`ifdef SOC_NOC_CREDIT_TX_ERR_EN
        chk("rst_err", err, 0);
`endif
        @(negedge clk);
        rst = 1'b1;

        // Contest between VC0 and VC1 from rr=0
        put(2'b11, 2'b00, 32'hC0, 32'hD0, 2'b00); chk("arb_rdy0", bus.in_ready, 2'b01); expect_flit(2'b01, 1'b0, 32'hC0);
        put(2'b11, 2'b01, 32'hC1, 32'hD0, 2'b00); chk("arb_rdy1", bus.in_ready, 2'b01); expect_flit(2'b01, 1'b1, 32'hC1);
        put(2'b11, 2'b00, 32'hE0, 32'hD0, 2'b00); chk("arb_rdy2", bus.in_ready, 2'b10); expect_flit(2'b10, 1'b0, 32'hD0);
        put(2'b11, 2'b10, 32'hE0, 32'hD1, 2'b00); chk("arb_rdy3", bus.in_ready, 2'b10); expect_flit(2'b10, 1'b1, 32'hD1);
        put(2'b01, 2'b01, 32'hE0, 32'h0, 2'b00);  chk("arb_rdy4", bus.in_ready, 2'b01); expect_flit(2'b01, 1'b1, 32'hE0);
        put(2'b00, 2'b00, '0, '0, 2'b11);
        chk("arb_cred0", cred(0), 1);
        chk("arb_cred1", cred(1), 2);
        put(2'b00, 2'b00, '0, '0, 2'b11);
        put(2'b00, 2'b00, '0, '0, 2'b01);
        idle();
        chk("arb_cred0_back", cred(0), 4);
        chk("arb_cred1_back", cred(1), 4);

        // VC0 3-flit packet, no returns
        put(2'b01, 2'b00, 32'hA0, '0, 2'b00); chk("p3_rdy0", bus.in_ready, 2'b01); expect_flit(2'b01, 1'b0, 32'hA0);
        put(2'b01, 2'b00, 32'hA1, '0, 2'b00); chk("p3_rdy1", bus.in_ready, 2'b01); expect_flit(2'b01, 1'b0, 32'hA1);
        put(2'b01, 2'b01, 32'hA2, '0, 2'b00); chk("p3_rdy2", bus.in_ready, 2'b01); expect_flit(2'b01, 1'b1, 32'hA2);
        idle();
        chk("p3_credit0", cred(0), 1);
        chk("p3_state", bus.dbg_state, 0);
        idle();
        chk("p3_link_idle", bus.link_valid, 0);
        for (int i = 0; i < 3; i++) put(2'b00, 2'b00, '0, '0, 2'b01);
        idle();
        chk("p3_cred_back", cred(0), 4);

        // VC0 6-flit packet starves after 4 flits and holds the lock
        for (int i = 0; i < 4; i++) begin
            put(2'b01, 2'b00, 32'hB0 + i, '0, 2'b00);
            chk("p6_rdy", bus.in_ready, 2'b01);
            expect_flit(2'b01, 1'b0, 32'hB0 + i);
        end
        put(2'b01, 2'b00, 32'hB4, '0, 2'b00); chk("p6_stall", bus.in_ready, 2'b00);
        chk("p6_locked", bus.dbg_state, 1);
        put(2'b01, 2'b00, 32'hB4, '0, 2'b01); chk("p6_no_comb_ret", bus.in_ready, 2'b00);
        expect_flit(2'b01, 1'b0, 32'hB4);
        put(2'b01, 2'b00, 32'hB4, '0, 2'b00); chk("p6_resume", bus.in_ready, 2'b01);
        put(2'b01, 2'b01, 32'hB5, '0, 2'b00); chk("p6_stall2", bus.in_ready, 2'b00);
        chk("p6_cred_zero", cred(0), 0);
        put(2'b01, 2'b01, 32'hB5, '0, 2'b01); chk("p6_stall3", bus.in_ready, 2'b00);
        expect_flit(2'b01, 1'b1, 32'hB5);
        put(2'b01, 2'b01, 32'hB5, '0, 2'b00); chk("p6_last_rdy", bus.in_ready, 2'b01);
        for (int i = 0; i < 4; i++) put(2'b00, 2'b00, '0, '0, 2'b01);
        idle();
        chk("p6_cred_back", cred(0), 4);
        chk("p6_state", bus.dbg_state, 0);

        // Return and spend on VC1 in the same cycle at credit 2
        put(2'b10, 2'b10, '0, 32'hF0, 2'b00); chk("cx_rdy0", bus.in_ready, 2'b10); expect_flit(2'b10, 1'b1, 32'hF0);
        put(2'b10, 2'b10, '0, 32'hF1, 2'b00); chk("cx_rdy1", bus.in_ready, 2'b10); expect_flit(2'b10, 1'b1, 32'hF1);
        put(2'b10, 2'b10, '0, 32'hF2, 2'b10); chk("cx_cred_pre", cred(1), 2);
        chk("cx_rdy2", bus.in_ready, 2'b10); expect_flit(2'b10, 1'b1, 32'hF2);
        idle();
        chk("cx_cred_post", cred(1), 2);
        put(2'b00, 2'b00, '0, '0, 2'b10);
        put(2'b00, 2'b00, '0, '0, 2'b10);
        idle();
        chk("cx_cred_back", cred(1), 4);

        // Reset in the middle of a VC0 packet
        put(2'b01, 2'b00, 32'h60, '0, 2'b00); chk("mr_rdy0", bus.in_ready, 2'b01); expect_flit(2'b01, 1'b0, 32'h60);
        put(2'b01, 2'b00, 32'h61, '0, 2'b00);
        #1 rst = 1'b0;
        #1;
        chk("mr_link_valid", bus.link_valid, 0);
        chk("mr_in_ready", bus.in_ready, 2'b00);
        chk("mr_credit0", cred(0), 4);
        chk("mr_credit1", cred(1), 4);
        chk("mr_state", bus.dbg_state, 0);
        bus.in_valid = '0;
        @(negedge clk);
        rst = 1'b1;
        put(2'b10, 2'b10, '0, 32'h70, 2'b00); chk("mr_vc1_rdy", bus.in_ready, 2'b10); expect_flit(2'b10, 1'b1, 32'h70);
        idle();
        idle();

`ifdef SOC_NOC_CREDIT_TX_ERR_EN
        put(2'b00, 2'b00, '0, '0, 2'b01); chk("err_pre", err, 0);
        idle();
        chk("err_set", err, 1);
        chk("err_cred", cred(0), 4);
        idle();
        idle();
        chk("err_sticky", err, 1);
        #1 rst = 1'b0;
        #1 chk("err_rst", err, 0);
        @(negedge clk);
        rst = 1'b1;
`endif

        idle();
        idle();
        chk("drain", exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/soc_noc_credit_tx.md
SOC_NOC_CREDIT_TX -- requirements
Module: soc_noc_credit_tx

Interface
REQ-001 SHALL have parameter FLIT_WIDTH, default 32: flit width in bits.
REQ-002 SHALL have parameter CHANNELS, default 2: number of virtual channels (VCs), at least 2.
REQ-003 SHALL have parameter CREDITS, default 4: receiver buffer depth per VC; counter width is $clog2(CREDITS+1).
REQ-004 SHALL have port clk, input, 1: single clock; all logic on its rising edge.
REQ-005 SHALL have port rst, input, 1: reset, asynchronous, active-low.
REQ-006 SHALL have port in_flit, input, CHANNELS x FLIT_WIDTH: per-VC upstream flit.
REQ-007 SHALL have port in_last, input, CHANNELS: per-VC last flit of packet.
REQ-008 SHALL have port in_valid, input, CHANNELS: per-VC flit valid.
REQ-009 SHALL have port in_ready, output, CHANNELS: per-VC accept.
REQ-010 SHALL have port link_flit, output, FLIT_WIDTH: registered link flit.
REQ-011 SHALL have port link_last, output, 1: registered last marker.
REQ-012 SHALL have port link_valid, output, 1: one-cycle flit strobe; there is no link ready.
REQ-013 SHALL have port link_vc, output, CHANNELS: one-hot VC of link_flit.
REQ-014 SHALL have port credit_return, input, CHANNELS: each one-cycle high bit returns one credit to that VC.

Function
REQ-015 SHALL keep one credit counter per VC; a VC is eligible only when in_valid is high and its credit is greater than 0.
REQ-016 SHALL implement FSM states IDLE and LOCKED, plus a round-robin pointer rr (reset 0) and a locked VC index sel.
REQ-017 In IDLE, SHALL grant the first eligible VC searching from rr upward with wrap-around, in the same cycle, and raise only that VC's in_ready.
REQ-018 In IDLE, a granted flit with in_last=1 (single-flit packet) SHALL keep IDLE and set rr to grant+1 mod CHANNELS.
REQ-019 In IDLE, a granted flit with in_last=0 SHALL move to LOCKED with sel set to the granted VC.
REQ-020 In LOCKED, in_ready[sel] SHALL equal credit[sel] > 0, and all other in_ready bits SHALL be 0.
REQ-021 In LOCKED, a transfer with in_last=1 SHALL return to IDLE and set rr to sel+1 mod CHANNELS.
REQ-022 Packets SHALL never interleave on the link; when a locked VC runs out of credits, the block SHALL stall and hold the lock.
REQ-023 On transfer (in_valid & in_ready), SHALL register link_flit, link_last and link_vc, and pulse link_valid next cycle; latency exactly 1 cycle; throughput 1 flit/cycle.
REQ-024 SHALL decrement credit on transfer and increment it on credit_return; both events in the same cycle on the same VC SHALL leave the credit unchanged.
REQ-025 A credit_return arriving with credit already equal to CREDITS SHALL saturate the counter and not wrap it.
REQ-026 When credit is 0 and credit_return arrives, the credit SHALL become usable on the next cycle; there is no combinational return-to-ready path.
REQ-027 in_ready SHALL never depend combinationally on credit_return.

Reset
REQ-028 On rst low, asynchronously: FSM SHALL go to IDLE, rr=0, sel=0, every credit=CREDITS.
REQ-029 On rst low, asynchronously: link_valid=0, link_last=0, link_flit=0, link_vc=0, in_ready=0.
REQ-030 A reset asserted mid-packet SHALL abandon the packet; after deassertion the block SHALL accept a new header on any VC.

Configuration
REQ-031 SHALL define macro SOC_NOC_CREDIT_TX_ERR_EN.
REQ-032 With SOC_NOC_CREDIT_TX_ERR_EN defined: output port err (1 bit, reset 0) SHALL be set sticky on any credit_return that hits a counter already at CREDITS, cleared only by reset.
REQ-033 Without SOC_NOC_CREDIT_TX_ERR_EN: port err SHALL be absent and overflow returns SHALL be silently saturated.

Verification
REQ-034 Scenario, CHANNELS=2, CREDITS=4: VC0 sends a 3-flit packet, no returns -> link_valid high for 3 cycles starting 1 cycle after the first transfer, link_vc=01, link_last on the 3rd flit, credit[0]=1.
REQ-035 Scenario: VC0 sends a 6-flit packet with no returns -> stall after 4 flits with in_ready=00; one credit_return[0] pulse -> exactly one more flit sent.
REQ-036 Scenario: VC0 and VC1 both valid with 2-flit packets, rr=0 -> VC0 packet sent whole, then VC1, with no interleave; a repeat of the contest starts with VC1.
REQ-037 Scenario: credit_return[1] while VC1 transfers at credit=2 -> credit[1] stays 2.
REQ-038 Scenario: rst low during flit 2 of a 4-flit packet, then released -> link_valid=0 and all credits=4; a fresh VC1 single-flit packet is then sent with link_vc=10.
REQ-039 Scenario, with SOC_NOC_CREDIT_TX_ERR_EN: credit_return[0] at credit=4 -> err=1 the next cycle, credit stays 4, err remains 1 until reset.
